// File: rtl/fifo_rd_if.sv
// Read-side bundle of the async FIFO: synchronized write pointer in, Gray read pointer out,
// RAM read port, and the first-word-fall-through consumer handshake with status.
// master = read controller, slave = the surrounding FIFO / RAM / consumer.
interface fifo_rd_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic [ADDR_W:0]   rq2_wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              rd_empty;
  logic              rd_almost_empty;
  logic [ADDR_W:0]   rd_level;

  modport master (
    input  rq2_wr_ptr, ram_rd_data, dout_ready,
    output rd_ptr, ram_rd_en, ram_rd_addr, dout, dout_valid,
           rd_empty, rd_almost_empty, rd_level
  );

  modport slave (
    output rq2_wr_ptr, ram_rd_data, dout_ready,
    input  rd_ptr, ram_rd_en, ram_rd_addr, dout, dout_valid,
           rd_empty, rd_almost_empty, rd_level
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: Gray/binary read pointer, empty/level status, FWFT output.
// Latency: 2 rd_clk edges from synchronized write pointer arrival to dout_valid.
// Backpressure: dout_ready low holds dout stable; no RAM read is issued until the held word is taken.
module fifo_rd_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 8,
  parameter int AE_THRESH = 1
) (
  input  logic      rd_clk,
  input  logic      rd_rst,
  fifo_rd_if.master rif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_VALID = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] AE_LIM = (ADDR_W+1)'(AE_THRESH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   rd_bin_q, rd_bin_d;
  logic [ADDR_W:0]   rd_gray_q, rd_gray_d;
  logic [ADDR_W:0]   rd_level_q, rd_level_d;
  logic              rd_empty_q, rd_empty_d;
  logic              rd_ae_q, rd_ae_d;
  logic [ADDR_W:0]   wr_bin;
  logic              pop;
  logic              dout_valid;
  logic [DATA_W-1:0] rd_word;

  // The output stage owns a word exactly while the FSM sits in VALID.
  assign dout_valid = (state_q == S_VALID);

  // Read the RAM when it holds a word and the output stage is free or being drained this cycle.
  assign pop = !rd_empty_q && (!dout_valid || rif.dout_ready);

  // Gray to binary for the synchronized write pointer: bit i is the XOR of all bits at or above i.
  always_comb begin
    wr_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      wr_bin[i] = ^(rif.rq2_wr_ptr >> i);
    end
  end

  // Next pointer and status, computed from the post-pop pointer so a simultaneous pop and
  // write arrival is counted correctly.
  always_comb begin
    rd_bin_d   = rd_bin_q + {{ADDR_W{1'b0}}, pop};
    rd_gray_d  = rd_bin_d ^ (rd_bin_d >> 1);
    rd_empty_d = (rd_gray_d == rif.rq2_wr_ptr);
    rd_level_d = wr_bin - rd_bin_d;
    rd_ae_d    = (rd_level_d <= AE_LIM);
  end

  // Pointer and status registers; reset leaves the FIFO looking empty.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_bin_q   <= '0;
      rd_gray_q  <= '0;
      rd_level_q <= '0;
      rd_empty_q <= 1'b1;
      rd_ae_q    <= 1'b1;
    end else begin
      rd_bin_q   <= rd_bin_d;
      rd_gray_q  <= rd_gray_d;
      rd_level_q <= rd_level_d;
      rd_empty_q <= rd_empty_d;
      rd_ae_q    <= rd_ae_d;
    end
  end

  // Output-stage state register; reset drops any in-flight word.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output-stage next state: fill on pop, drain when the consumer takes the word with nothing behind it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (pop) state_d = S_VALID;
      S_VALID: if (rif.dout_ready && !pop) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // RAM output register holds its word while no read is issued, so it is the FWFT data directly.
  assign rd_word             = rif.ram_rd_data;
  assign rif.dout            = rd_word;
  assign rif.dout_valid      = dout_valid;
  assign rif.ram_rd_en       = pop;
  assign rif.ram_rd_addr     = rd_bin_q[ADDR_W-1:0];
  assign rif.rd_ptr          = rd_gray_q;
  assign rif.rd_empty        = rd_empty_q;
  assign rif.rd_almost_empty = rd_ae_q;
  assign rif.rd_level        = rd_level_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios plus randomized traffic.
// A word-count reference model (writes vs. reads, one-word output stage) runs alongside.
// The RAM is a behavioural array with a registered read port.
module tb_fifo_rd_ctrl;

  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;
  always #5 rd_clk = ~rd_clk;

  fifo_rd_if #(.ADDR_W(3), .DATA_W(8)) rif ();

  fifo_rd_ctrl #(.ADDR_W(3), .DATA_W(8), .AE_THRESH(1)) dut (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .rif    (rif)
  );

  // Behavioural dual-port RAM, read side registered
  logic [7:0] mem [0:7];
  logic [7:0] ram_q = 8'h00;
  assign rif.ram_rd_data = ram_q;
  always @(posedge rd_clk) if (rif.ram_rd_en === 1'b1) ram_q <= mem[rif.ram_rd_addr];

  // Write-side bookkeeping and reference model state
  logic [7:0] hist [0:1023];
  int         wr_cnt = 0;
  int         nvec = 0;
  int         nerr = 0;
  int         m_rd = 0;
  int         m_level = 0;
  logic       m_valid = 1'b0;
  logic       m_empty = 1'b1;
  logic [7:0] m_dout = 8'h00;
  logic       exp_pop;

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    logic [3:0] wb;
    hist[wr_cnt % 1024] = w;
    mem[wr_cnt % 8]     = w;
    wr_cnt              = wr_cnt + 1;
    wb                  = wr_cnt[3:0];
    rif.rq2_wr_ptr      = gray4(wb);
  endtask

  task automatic do_reset();
    rd_rst         = 1'b1;
    wr_cnt         = 0;
    rif.rq2_wr_ptr = 4'b0000;
    rif.dout_ready = 1'b0;
    tick();
    tick();
    rd_rst = 1'b0;
    tick();
  endtask

  // Continuous scoreboard: compares every output against the count model between edges,
  // then advances the model for the coming edge.
  always @(negedge rd_clk) begin
    if (rd_rst) begin
      m_rd = 0; m_level = 0; m_valid = 1'b0; m_empty = 1'b1;
      nvec++;
      if (rif.ram_rd_en !== 1'b0) begin nerr++; $display("FAIL sb_rst_rden t=%0t got=%b exp=0", $time, rif.ram_rd_en); end
    end else begin
      exp_pop = !m_empty && (!m_valid || rif.dout_ready);
      nvec += 7;
      if (rif.ram_rd_en !== exp_pop) begin nerr++; $display("FAIL sb_pop t=%0t got=%b exp=%b", $time, rif.ram_rd_en, exp_pop); end
      if (rif.ram_rd_addr !== 3'(m_rd % 8)) begin nerr++; $display("FAIL sb_addr t=%0t got=%0d exp=%0d", $time, rif.ram_rd_addr, m_rd % 8); end
      if (rif.rd_ptr !== gray4(4'(m_rd % 16))) begin nerr++; $display("FAIL sb_rdptr t=%0t got=%b exp=%b", $time, rif.rd_ptr, gray4(4'(m_rd % 16))); end
      if (rif.rd_empty !== m_empty) begin nerr++; $display("FAIL sb_empty t=%0t got=%b exp=%b", $time, rif.rd_empty, m_empty); end
      if (rif.rd_level !== 4'(m_level)) begin nerr++; $display("FAIL sb_level t=%0t got=%0d exp=%0d", $time, rif.rd_level, m_level); end
      if (rif.rd_almost_empty !== (m_level <= 1)) begin nerr++; $display("FAIL sb_ae t=%0t got=%b exp=%b", $time, rif.rd_almost_empty, (m_level <= 1)); end
      if (rif.dout_valid !== m_valid) begin nerr++; $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, rif.dout_valid, m_valid); end
      if (m_valid) begin
        nvec++;
        if (rif.dout !== m_dout) begin nerr++; $display("FAIL sb_dout t=%0t got=%h exp=%h", $time, rif.dout, m_dout); end
      end
      if (exp_pop) begin
        m_dout  = hist[m_rd % 1024];
        m_valid = 1'b1;
        m_rd    = m_rd + 1;
      end else if (rif.dout_ready) begin
        m_valid = 1'b0;
      end
      m_level = wr_cnt - m_rd;
      m_empty = (m_level == 0);
    end
  end

  task automatic test_reset();
    rd_rst         = 1'b1;
    rif.dout_ready = 1'b0;
    rif.rq2_wr_ptr = 4'b0000;
    wr_cnt         = 0;
    repeat (3) tick();
    nvec += 7;
    if (rif.rd_ptr !== 4'b0000) begin nerr++; $display("FAIL rst_rdptr got=%b exp=0000", rif.rd_ptr); end
    if (rif.ram_rd_addr !== 3'd0) begin nerr++; $display("FAIL rst_addr got=%0d exp=0", rif.ram_rd_addr); end
    if (rif.rd_empty !== 1'b1) begin nerr++; $display("FAIL rst_empty got=%b exp=1", rif.rd_empty); end
    if (rif.rd_almost_empty !== 1'b1) begin nerr++; $display("FAIL rst_ae got=%b exp=1", rif.rd_almost_empty); end
    if (rif.rd_level !== 4'd0) begin nerr++; $display("FAIL rst_level got=%0d exp=0", rif.rd_level); end
    if (rif.dout_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got=%b exp=0", rif.dout_valid); end
    if (rif.ram_rd_en !== 1'b0) begin nerr++; $display("FAIL rst_rden got=%b exp=0", rif.ram_rd_en); end
    rd_rst = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    rif.dout_ready = 1'b0;
    push(8'hA5);
    tick();
    nvec += 3;
    if (rif.rd_empty !== 1'b0) begin nerr++; $display("FAIL single_empty_fall got=%b exp=0", rif.rd_empty); end
    if (rif.ram_rd_en !== 1'b1) begin nerr++; $display("FAIL single_rden got=%b exp=1", rif.ram_rd_en); end
    if (rif.ram_rd_addr !== 3'd0) begin nerr++; $display("FAIL single_addr got=%0d exp=0", rif.ram_rd_addr); end
    tick();
    nvec += 4;
    if (rif.dout_valid !== 1'b1) begin nerr++; $display("FAIL single_valid got=%b exp=1", rif.dout_valid); end
    if (rif.dout !== 8'hA5) begin nerr++; $display("FAIL single_dout got=%h exp=a5", rif.dout); end
    if (rif.rd_ptr !== 4'b0001) begin nerr++; $display("FAIL single_rdptr got=%b exp=0001", rif.rd_ptr); end
    if (rif.rd_empty !== 1'b1) begin nerr++; $display("FAIL single_empty_rise got=%b exp=1", rif.rd_empty); end
    rif.dout_ready = 1'b1;
    tick();
    rif.dout_ready = 1'b0;
    nvec++;
    if (rif.dout_valid !== 1'b0) begin nerr++; $display("FAIL single_drain got=%b exp=0", rif.dout_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    push(8'h11); push(8'h22); push(8'h33);
    repeat (5) tick();
    nvec += 5;
    if (rif.dout !== 8'h11) begin nerr++; $display("FAIL bp_dout_hold got=%h exp=11", rif.dout); end
    if (rif.rd_level !== 4'd2) begin nerr++; $display("FAIL bp_level got=%0d exp=2", rif.rd_level); end
    if (rif.rd_almost_empty !== 1'b0) begin nerr++; $display("FAIL bp_ae got=%b exp=0", rif.rd_almost_empty); end
    if (rif.rd_ptr !== 4'b0001) begin nerr++; $display("FAIL bp_one_pop got=%b exp=0001", rif.rd_ptr); end
    if (rif.ram_rd_en !== 1'b0) begin nerr++; $display("FAIL bp_no_rden got=%b exp=0", rif.ram_rd_en); end
    rif.dout_ready = 1'b1;
    tick();
    rif.dout_ready = 1'b0;
    repeat (2) tick();
    nvec += 4;
    if (rif.dout !== 8'h22) begin nerr++; $display("FAIL bp_dout_next got=%h exp=22", rif.dout); end
    if (rif.rd_level !== 4'd1) begin nerr++; $display("FAIL bp_level2 got=%0d exp=1", rif.rd_level); end
    if (rif.rd_almost_empty !== 1'b1) begin nerr++; $display("FAIL bp_ae2 got=%b exp=1", rif.rd_almost_empty); end
    if (rif.rd_ptr !== 4'b0011) begin nerr++; $display("FAIL bp_two_pops got=%b exp=0011", rif.rd_ptr); end
  endtask

  task automatic test_streaming();
    int pops = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(i));
    rif.dout_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (rif.ram_rd_en === 1'b1) begin
        nvec++;
        if (rif.ram_rd_addr !== 3'(pops)) begin nerr++; $display("FAIL stream_addr got=%0d exp=%0d", rif.ram_rd_addr, pops); end
        if (first < 0) first = c;
        last = c;
        pops++;
      end
      if (rif.dout_valid === 1'b1) begin
        nvec++;
        if (rif.dout !== 8'(got)) begin nerr++; $display("FAIL stream_dout got=%h exp=%h", rif.dout, 8'(got)); end
        got++;
      end
      tick();
    end
    nvec += 5;
    if (pops != 8) begin nerr++; $display("FAIL stream_pops got=%0d exp=8", pops); end
    if (got != 8) begin nerr++; $display("FAIL stream_words got=%0d exp=8", got); end
    if (last - first != 7) begin nerr++; $display("FAIL stream_b2b got=%0d exp=7", last - first); end
    if (rif.rd_ptr !== 4'b1100) begin nerr++; $display("FAIL stream_rdptr got=%b exp=1100", rif.rd_ptr); end
    if (rif.rd_empty !== 1'b1) begin nerr++; $display("FAIL stream_empty got=%b exp=1", rif.rd_empty); end
  endtask

  task automatic test_wrap();
    int pops = 0;
    int cyc = 0;
    int cap;
    int n;
    while (!(m_rd == 16 && !m_valid) && cyc < 300) begin
      rif.dout_ready = 1'($urandom_range(0, 1));
      if (wr_cnt < 16 && $urandom_range(0, 1) == 1) begin
        cap = 8 - (wr_cnt - m_rd);
        n   = $urandom_range(1, 4);
        if (n > cap) n = cap;
        if (n > 16 - wr_cnt) n = 16 - wr_cnt;
        for (int k = 0; k < n; k++) push(8'($urandom));
      end
      #1;
      if (rif.ram_rd_en === 1'b1) begin
        nvec++;
        if (rif.ram_rd_addr !== 3'((8 + pops) % 8)) begin nerr++; $display("FAIL wrap_addr got=%0d exp=%0d", rif.ram_rd_addr, (8 + pops) % 8); end
        pops++;
      end
      tick();
      cyc++;
    end
    nvec += 4;
    if (cyc >= 300) begin nerr++; $display("FAIL wrap_timeout got=%0d cycles exp<300", cyc); end
    if (pops != 8) begin nerr++; $display("FAIL wrap_pops got=%0d exp=8", pops); end
    if (rif.rd_ptr !== 4'b0000) begin nerr++; $display("FAIL wrap_rdptr got=%b exp=0000", rif.rd_ptr); end
    if (rif.rd_empty !== 1'b1) begin nerr++; $display("FAIL wrap_empty got=%b exp=1", rif.rd_empty); end
    rif.dout_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    int cyc = 0;
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    rif.dout_ready = 1'b1;
    while (n < 4 && cyc < 30) begin
      tick();
      if (rif.ram_rd_en === 1'b1) n++;
      cyc++;
    end
    nvec++;
    if (n != 4) begin nerr++; $display("FAIL mid_reach_word4 got=%0d exp=4", n); end
    rd_rst         = 1'b1;
    wr_cnt         = 0;
    rif.rq2_wr_ptr = 4'b0000;
    #1;
    nvec += 7;
    if (rif.rd_ptr !== 4'b0000) begin nerr++; $display("FAIL mid_rdptr got=%b exp=0000", rif.rd_ptr); end
    if (rif.ram_rd_addr !== 3'd0) begin nerr++; $display("FAIL mid_addr got=%0d exp=0", rif.ram_rd_addr); end
    if (rif.rd_empty !== 1'b1) begin nerr++; $display("FAIL mid_empty got=%b exp=1", rif.rd_empty); end
    if (rif.rd_almost_empty !== 1'b1) begin nerr++; $display("FAIL mid_ae got=%b exp=1", rif.rd_almost_empty); end
    if (rif.rd_level !== 4'd0) begin nerr++; $display("FAIL mid_level got=%0d exp=0", rif.rd_level); end
    if (rif.dout_valid !== 1'b0) begin nerr++; $display("FAIL mid_valid got=%b exp=0", rif.dout_valid); end
    if (rif.ram_rd_en !== 1'b0) begin nerr++; $display("FAIL mid_rden got=%b exp=0", rif.ram_rd_en); end
    for (int c = 0; c < 3; c++) begin
      tick();
      nvec++;
      if (rif.ram_rd_en !== 1'b0 || rif.dout_valid !== 1'b0) begin nerr++; $display("FAIL mid_hold got=%b%b exp=00", rif.ram_rd_en, rif.dout_valid); end
    end
    rd_rst = 1'b0;
    tick();
    nvec++;
    if (rif.rd_empty !== 1'b1) begin nerr++; $display("FAIL mid_release_empty got=%b exp=1", rif.rd_empty); end
    rif.dout_ready = 1'b0;
  endtask

  task automatic test_random();
    int cap;
    int n;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rif.dout_ready = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        cap = 8 - (wr_cnt - m_rd);
        n   = $urandom_range(1, 8);
        if (n > cap) n = cap;
        for (int k = 0; k < n; k++) push(8'($urandom));
      end
      tick();
    end
    rif.dout_ready = 1'b1;
    repeat (20) tick();
    nvec += 3;
    if (rif.rd_level !== 4'd0) begin nerr++; $display("FAIL rand_drain_level got=%0d exp=0", rif.rd_level); end
    if (rif.dout_valid !== 1'b0) begin nerr++; $display("FAIL rand_drain_valid got=%b exp=0", rif.dout_valid); end
    if (rif.rd_ptr !== gray4(4'(wr_cnt % 16))) begin nerr++; $display("FAIL rand_drain_rdptr got=%b exp=%b", rif.rd_ptr, gray4(4'(wr_cnt % 16))); end
    rif.dout_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rif.dout_ready = 1'b0;
    rif.rq2_wr_ptr = 4'b0000;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    test_reset();
    test_single_word();
    test_backpressure();
    test_streaming();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
